// File: rtl/qam_pkg.sv
// ---------------------------------------------------------------------------
// qam_pkg
// Shared definitions for the 16-QAM receive path.
//   - default widths for the symbol, carrier table and input sample
//   - Gray-coded per-axis level constants
//   - demodulator FSM state type
//   - per-axis slicer function (signed integral vs. unsigned threshold)
// ---------------------------------------------------------------------------
package qam_pkg;

    localparam int DEF_QAM_WIDTH  = 4;
    localparam int DEF_WAVE_WIDTH = 16;
    localparam int DEF_IN_WIDTH   = DEF_QAM_WIDTH + DEF_WAVE_WIDTH + 1;

    // Slicer operands are sign-extended to this width so one function
    // serves any accumulator width up to 64 bits.
    localparam int SLICE_WIDTH = 64;

    // Gray-coded levels: neighbouring amplitudes differ in one bit.
    localparam logic [1:0] LVL_N3 = 2'b00;
    localparam logic [1:0] LVL_N1 = 2'b01;
    localparam logic [1:0] LVL_P1 = 2'b11;
    localparam logic [1:0] LVL_P3 = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DECIDE
    } demod_state_t;

    // Exact boundaries land on the level nearer zero except +T, which is
    // treated as an outer level: 0 -> +1, T -> +3, -T -> -1.
    function automatic logic [1:0] qam_slice(
        input logic signed [SLICE_WIDTH-1:0] acc,
        input logic signed [SLICE_WIDTH-1:0] thr
    );
        logic [1:0] lvl;
        if (acc >= thr) begin
            lvl = LVL_P3;
        end else if (acc >= 0) begin
            lvl = LVL_P1;
        end else if (acc >= -thr) begin
            lvl = LVL_N1;
        end else begin
            lvl = LVL_N3;
        end
        return lvl;
    endfunction

endpackage

// File: rtl/qam_carrier_lut.sv
// ---------------------------------------------------------------------------
// qam_carrier_lut
// Combinational cos/sin carrier table, one carrier cycle over N samples.
//   cos_k = round(cos(2*pi*k/N) * (2^(WAVE_WIDTH-1)-1)), sin_k likewise.
// Ports:
//   i_index  sample index within the symbol (0..N-1)
//   o_cos    signed cosine table entry for i_index
//   o_sin    signed sine table entry for i_index
// ---------------------------------------------------------------------------
module qam_carrier_lut #(
    parameter int N          = 16,
    parameter int WAVE_WIDTH = 16,
    localparam int IDX_W     = $clog2(N)
) (
    input  logic        [IDX_W-1:0]      i_index,
    output logic signed [WAVE_WIDTH-1:0] o_cos,
    output logic signed [WAVE_WIDTH-1:0] o_sin
);

    localparam real PI   = 3.14159265358979323846;
    localparam real PEAK = real'((2 ** (WAVE_WIDTH - 1)) - 1);

    logic signed [WAVE_WIDTH-1:0] w_cosTab [N];
    logic signed [WAVE_WIDTH-1:0] w_sinTab [N];

    // Table entries are elaboration-time constants; the real-to-int cast
    // rounds to nearest, so the quadrature zeros come out as exact 0.
    for (genvar k = 0; k < N; k++) begin : g_tab
        localparam real ANG   = 2.0 * PI * real'(k) / real'(N);
        localparam int  COS_V = int'($cos(ANG) * PEAK);
        localparam int  SIN_V = int'($sin(ANG) * PEAK);
        assign w_cosTab[k] = WAVE_WIDTH'(COS_V);
        assign w_sinTab[k] = WAVE_WIDTH'(SIN_V);
    end

    assign o_cos = w_cosTab[i_index];
    assign o_sin = w_sinTab[i_index];

endmodule

// File: rtl/qam_demodulator.sv
// ---------------------------------------------------------------------------
// qam_demodulator
// 16-QAM demodulator: mixes received samples with a local cos/sin carrier,
// integrates I and Q over one symbol, slices each axis to a Gray level and
// emits the 4-bit symbol with a one-cycle valid strobe.
// Ports:
//   clk, reset    clock and synchronous active-high reset
//   rx_sample     signed received sample, qualified by in_valid
//   in_ready      low only during the single decision cycle
//   sync_in       marks the accepted sample as symbol index 0
//   thresh        unsigned outer/inner level boundary for the slicer
//   data_out      recovered symbol, [3:2] = I level, [1:0] = Q level
//   data_valid    one-cycle strobe when data_out updates
//   sync_err_cnt  (only with QAM_DEMOD_SYNCERR_EN) saturating count of
//                 mid-symbol resynchronisations
// ---------------------------------------------------------------------------
module qam_demodulator
    import qam_pkg::*;
#(
    parameter int QAM_WIDTH       = DEF_QAM_WIDTH,
    parameter int WAVE_WIDTH      = DEF_WAVE_WIDTH,
    parameter int IN_WIDTH        = QAM_WIDTH + WAVE_WIDTH + 1,
    parameter int SAMPLES_PER_SYM = 16,
    parameter int ACC_WIDTH       = IN_WIDTH + WAVE_WIDTH + $clog2(SAMPLES_PER_SYM)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic signed [IN_WIDTH-1:0]  rx_sample,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        sync_in,
    input  logic        [ACC_WIDTH-2:0] thresh,
    output logic        [QAM_WIDTH-1:0] data_out,
    output logic                        data_valid
`ifdef QAM_DEMOD_SYNCERR_EN
    ,
    output logic        [15:0]          sync_err_cnt
`endif
);

    localparam int IDX_W = $clog2(SAMPLES_PER_SYM);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLES_PER_SYM - 1);

    demod_state_t r_state;
    demod_state_t w_nextState;

    logic                        w_inReady;
    logic                        w_accept;
    logic                        w_resync;
    logic        [IDX_W-1:0]     r_index;
    logic        [IDX_W-1:0]     w_lutIdx;
    logic signed [WAVE_WIDTH-1:0] w_cos;
    logic signed [WAVE_WIDTH-1:0] w_sin;
    logic signed [ACC_WIDTH-1:0] w_prodI;
    logic signed [ACC_WIDTH-1:0] w_prodQ;
    logic signed [ACC_WIDTH-1:0] r_iAcc;
    logic signed [ACC_WIDTH-1:0] r_qAcc;
    logic        [QAM_WIDTH-1:0] r_dataOut;
    logic                        r_dataValid;
`ifdef QAM_DEMOD_SYNCERR_EN
    logic        [15:0]          r_syncErrCnt;
`endif

    assign w_accept = in_valid && w_inReady;
    assign w_resync = (r_state == ST_ACCUM) && w_accept && sync_in && (r_index != '0);

    // A sync-marked sample always mixes with the index-0 carrier, which is
    // what makes a resync reload the accumulators with fresh products.
    assign w_lutIdx = sync_in ? '0 : r_index;

    qam_carrier_lut #(
        .N          (SAMPLES_PER_SYM),
        .WAVE_WIDTH (WAVE_WIDTH)
    ) u_lut (
        .i_index (w_lutIdx),
        .o_cos   (w_cos),
        .o_sin   (w_sin)
    );

    // Operands are sign-extended to the accumulator width; the product
    // always fits, so truncating the multiply result loses nothing.
    assign w_prodI = ACC_WIDTH'(rx_sample) * ACC_WIDTH'(w_cos);
    assign w_prodQ = ACC_WIDTH'(rx_sample) * ACC_WIDTH'(w_sin);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // A resync on the last index stays in ACCUM because the reloaded
    // symbol has only just started.
    always_comb begin
        w_nextState = r_state;
        w_inReady   = 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && sync_in) begin
                    w_nextState = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (w_accept && !w_resync && (r_index == LAST_IDX)) begin
                    w_nextState = ST_DECIDE;
                end
            end
            ST_DECIDE: begin
                w_inReady   = 1'b0;
                w_nextState = ST_ACCUM;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Index is log2(N) bits wide, so incrementing past N-1 wraps to 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_index     <= '0;
            r_iAcc      <= '0;
            r_qAcc      <= '0;
            r_dataOut   <= '0;
            r_dataValid <= 1'b0;
        end else begin
            r_dataValid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && sync_in) begin
                        r_iAcc  <= w_prodI;
                        r_qAcc  <= w_prodQ;
                        r_index <= IDX_W'(1);
                    end
                end
                ST_ACCUM: begin
                    if (w_resync) begin
                        r_iAcc  <= w_prodI;
                        r_qAcc  <= w_prodQ;
                        r_index <= IDX_W'(1);
                    end else if (w_accept) begin
                        r_iAcc  <= r_iAcc + w_prodI;
                        r_qAcc  <= r_qAcc + w_prodQ;
                        r_index <= r_index + 1'b1;
                    end
                end
                ST_DECIDE: begin
                    r_dataOut   <= QAM_WIDTH'({qam_slice(SLICE_WIDTH'(r_iAcc), SLICE_WIDTH'({1'b0, thresh})),
                                               qam_slice(SLICE_WIDTH'(r_qAcc), SLICE_WIDTH'({1'b0, thresh}))});
                    r_dataValid <= 1'b1;
                    r_iAcc      <= '0;
                    r_qAcc      <= '0;
                    r_index     <= '0;
                end
                default: begin
                    r_index <= '0;
                end
            endcase
        end
    end

`ifdef QAM_DEMOD_SYNCERR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_syncErrCnt <= '0;
        end else if (w_resync && (r_syncErrCnt != 16'hFFFF)) begin
            r_syncErrCnt <= r_syncErrCnt + 16'd1;
        end
    end

    assign sync_err_cnt = r_syncErrCnt;
`endif

    assign in_ready   = w_inReady;
    assign data_out   = r_dataOut;
    assign data_valid = r_dataValid;

endmodule
